// File: rtl/firstband_predictor_2d_pkg.sv
// Shared definitions for the first-band 2D spatial predictor.
//   pred_mode_e : predictor selection latched at the start of each block
//   med_sel_e   : which operand the median edge detector picks
//   med_select  : MED decision on zero-extended operands. The caller forms
//                 the chosen value at its own width, which keeps this
//                 function independent of the sample width.
package firstband_predictor_2d_pkg;

  typedef enum logic [1:0] {
    LEFT = 2'd0,
    UP   = 2'd1,
    AVG  = 2'd2,
    MED  = 2'd3
  } pred_mode_e;

  typedef enum logic [1:0] {
    MED_SEL_MIN  = 2'd0,
    MED_SEL_MAX  = 2'd1,
    MED_SEL_GRAD = 2'd2
  } med_sel_e;

  // Widest sample the MED comparison supports.
  localparam int MED_MAX_W = 32;

  // Median edge detector:
  //   upleft >= max(left,up) -> min(left,up)
  //   upleft <= min(left,up) -> max(left,up)
  //   otherwise              -> left + up - upleft
  function automatic med_sel_e med_select(
    input logic [MED_MAX_W-1:0] left,
    input logic [MED_MAX_W-1:0] up,
    input logic [MED_MAX_W-1:0] upleft
  );
    logic [MED_MAX_W-1:0] mx;
    logic [MED_MAX_W-1:0] mn;
    mx = (left > up) ? left : up;
    mn = (left > up) ? up : left;
    if (upleft >= mx) begin
      med_select = MED_SEL_MIN;
    end else if (upleft <= mn) begin
      med_select = MED_SEL_MAX;
    end else begin
      med_select = MED_SEL_GRAD;
    end
  endfunction

endpackage

// File: rtl/firstband_line_buffer.sv
// One-row delay line for the first-band predictor.
// Each write pushes i_din in. o_dout is the sample written 2^DEPTH_LOG
// writes earlier, which is the pixel directly above the current one when
// the block width equals the depth.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset (pointer only, contents kept)
//   i_we   : write enable (one input transfer)
//   i_din  : sample to store
//   o_dout : oldest sample, read before this cycle's write
module firstband_line_buffer
  import firstband_predictor_2d_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_LOG  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [DATA_WIDTH-1:0] i_din,
  output logic [DATA_WIDTH-1:0] o_dout
);

  logic [DATA_WIDTH-1:0] r_mem [2**DEPTH_LOG];
  logic [DEPTH_LOG-1:0]  r_ptr;

  // Pointer realignment on reset is harmless: a full row is written
  // before any up sample is used.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (i_we) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[r_ptr] <= i_din;
    end
  end

  // The slot about to be overwritten holds the oldest sample.
  assign o_dout = r_mem[r_ptr];

endmodule

// File: rtl/firstband_predictor_2d.sv
// First-band 2D spatial predictor with AXI-stream input and output.
// Samples arrive in raster order within blocks of
// 2^BLOCK_WIDTH_LOG x 2^BLOCK_HEIGHT_LOG. Each sample gets a prediction
// from its left/up/upleft neighbours and a residual x - prediction,
// presented one cycle after the input transfer.
// Ports:
//   clk, rst             : clock; asynchronous active-low reset
//   x_valid/x_ready      : input handshake
//   x_data               : unsigned input sample
//   mode                 : predictor mode, latched on the first sample of a block
//   prediction_valid/_ready : output handshake
//   prediction_data      : unsigned prediction
//   residual_data        : two's-complement residual, DATA_WIDTH+1 bits
//   prediction_last      : marks the final sample of each block
module firstband_predictor_2d
  import firstband_predictor_2d_pkg::*;
#(
  parameter int DATA_WIDTH       = 16,
  parameter int BLOCK_WIDTH_LOG  = 4,
  parameter int BLOCK_HEIGHT_LOG = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  x_valid,
  output logic                  x_ready,
  input  logic [DATA_WIDTH-1:0] x_data,
  input  logic [1:0]            mode,
  output logic                  prediction_valid,
  input  logic                  prediction_ready,
  output logic [DATA_WIDTH-1:0] prediction_data,
  output logic [DATA_WIDTH:0]   residual_data,
  output logic                  prediction_last
);

  // Floor of the mean, with the sum formed one bit wider to avoid overflow.
  function automatic logic [DATA_WIDTH-1:0] avg_floor(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    avg_floor = DATA_WIDTH'(sum >> 1);
  endfunction

  logic                         w_fire_in;
  logic [BLOCK_WIDTH_LOG-1:0]   r_col;
  logic [BLOCK_HEIGHT_LOG-1:0]  r_row;
  pred_mode_e                   r_mode;
  logic                         w_start;
  logic                         w_col_last;
  logic                         w_row_last;

  logic [DATA_WIDTH-1:0]        w_up;
  logic [DATA_WIDTH-1:0]        r_left;
  logic [DATA_WIDTH-1:0]        r_upleft;
  logic [DATA_WIDTH-1:0]        w_min;
  logic [DATA_WIDTH-1:0]        w_max;
  logic [DATA_WIDTH-1:0]        w_grad;
  med_sel_e                     w_med_sel;
  logic [DATA_WIDTH-1:0]        w_pred;
  logic signed [DATA_WIDTH:0]   w_res;

  logic                         r_vld_p1;
  logic [DATA_WIDTH-1:0]        r_pred_p1;
  logic signed [DATA_WIDTH:0]   r_res_p1;
  logic                         r_last_p1;

  // A new sample is accepted whenever the output register is free or draining.
  assign x_ready    = prediction_ready | ~r_vld_p1;
  assign w_fire_in  = x_valid & x_ready;

  assign w_start    = (r_col == '0) && (r_row == '0);
  assign w_col_last = &r_col;
  assign w_row_last = &r_row;

  // Position counters and per-block mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col  <= '0;
      r_row  <= '0;
      r_mode <= LEFT;
    end else if (w_fire_in) begin
      r_col <= r_col + 1'b1;
      if (w_col_last) begin
        r_row <= r_row + 1'b1;
      end
      if (w_start) begin
        r_mode <= pred_mode_e'(mode);
      end
    end
  end

  firstband_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG  (BLOCK_WIDTH_LOG)
  ) u_line_buffer (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_fire_in),
    .i_din  (x_data),
    .o_dout (w_up)
  );

  // Left and upleft neighbours; zeroed on the last column so every row
  // starts clean. They are only consumed from column 1 onward.
  always_ff @(posedge clk) begin
    if (w_fire_in) begin
      if (w_col_last) begin
        r_left   <= '0;
        r_upleft <= '0;
      end else begin
        r_left   <= x_data;
        r_upleft <= w_up;
      end
    end
  end

  assign w_min     = (r_left > w_up) ? w_up : r_left;
  assign w_max     = (r_left > w_up) ? r_left : w_up;
  // Only selected when upleft lies strictly between min and max, so the
  // modular result is exact.
  assign w_grad    = r_left + w_up - r_upleft;
  assign w_med_sel = med_select(MED_MAX_W'(r_left), MED_MAX_W'(w_up),
                                MED_MAX_W'(r_upleft));

  // Position decides first; the latched mode only applies in the interior.
  always_comb begin
    w_pred = '0;
    if (w_start) begin
      w_pred = '0;
    end else if (r_row == '0) begin
      w_pred = r_left;
    end else if (r_col == '0) begin
      w_pred = w_up;
    end else begin
      case (r_mode)
        LEFT: w_pred = r_left;
        UP:   w_pred = w_up;
        AVG:  w_pred = avg_floor(r_left, w_up);
        MED: begin
          case (w_med_sel)
            MED_SEL_MIN: w_pred = w_min;
            MED_SEL_MAX: w_pred = w_max;
            default:     w_pred = w_grad;
          endcase
        end
        default: w_pred = '0;
      endcase
    end
  end

  assign w_res = signed'({1'b0, x_data}) - signed'({1'b0, w_pred});

  // ---- stage p1: output register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p1  <= 1'b0;
      r_pred_p1 <= '0;
      r_res_p1  <= '0;
      r_last_p1 <= 1'b0;
    end else begin
      if (w_fire_in) begin
        r_vld_p1  <= 1'b1;
        r_pred_p1 <= w_pred;
        r_res_p1  <= w_res;
        r_last_p1 <= w_col_last & w_row_last;
      end else if (prediction_ready) begin
        r_vld_p1  <= 1'b0;
      end
    end
  end

  assign prediction_valid = r_vld_p1;
  assign prediction_data  = r_pred_p1;
  assign residual_data    = r_res_p1;
  assign prediction_last  = r_last_p1;

endmodule

// File: tb/tb_firstband_predictor_2d.sv
// Scoreboard bench for firstband_predictor_2d with 4x4 blocks.
module tb_firstband_predictor_2d;

  localparam int DW  = 16;
  localparam int BWL = 2;
  localparam int BHL = 2;
  localparam int NC  = 4;
  localparam int NR  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          x_valid;
  logic          x_ready;
  logic [DW-1:0] x_data;
  logic [1:0]    mode;
  logic          prediction_valid;
  logic          prediction_ready;
  logic [DW-1:0] prediction_data;
  logic [DW:0]   residual_data;
  logic          prediction_last;

  always #5 clk = ~clk;

  firstband_predictor_2d #(
    .DATA_WIDTH       (DW),
    .BLOCK_WIDTH_LOG  (BWL),
    .BLOCK_HEIGHT_LOG (BHL)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .x_valid          (x_valid),
    .x_ready          (x_ready),
    .x_data           (x_data),
    .mode             (mode),
    .prediction_valid (prediction_valid),
    .prediction_ready (prediction_ready),
    .prediction_data  (prediction_data),
    .residual_data    (residual_data),
    .prediction_last  (prediction_last)
  );

  typedef struct packed {
    logic [DW-1:0] pred;
    logic [DW:0]   res;
    logic          last;
  } item_t;

  item_t exp_q[$];
  item_t got_q[$];
  item_t mon_g;
  item_t mon_e;

  int errors = 0;
  int checks = 0;

  // Reference image model: previous and current row of the block.
  int m_col, m_row, m_mode;
  int m_prev[NC];
  int m_cur[NC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int median3(input int a, input int b, input int c);
    if ((a <= b && b <= c) || (c <= b && b <= a)) return b;
    if ((b <= a && a <= c) || (c <= a && a <= b)) return a;
    return c;
  endfunction

  task automatic model_reset();
    m_col = 0;
    m_row = 0;
  endtask

  task automatic model_push(input int x, input int md);
    int p, l, u, ul;
    item_t it;
    if (m_col == 0 && m_row == 0) m_mode = md;
    l  = (m_col > 0) ? m_cur[m_col-1] : 0;
    u  = m_prev[m_col];
    ul = (m_col > 0) ? m_prev[m_col-1] : 0;
    if (m_row == 0 && m_col == 0) p = 0;
    else if (m_row == 0)          p = l;
    else if (m_col == 0)          p = u;
    else begin
      case (m_mode)
        0:       p = l;
        1:       p = u;
        2:       p = (l + u) / 2;
        default: p = median3(l, u, l + u - ul);
      endcase
    end
    m_cur[m_col] = x;
    it.pred = p[DW-1:0];
    it.res  = (DW+1)'(x - p);
    it.last = (m_col == NC-1) && (m_row == NR-1);
    exp_q.push_back(it);
    if (m_col == NC-1) begin
      m_prev = m_cur;
      m_col  = 0;
      m_row  = (m_row + 1) % NR;
    end else begin
      m_col++;
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [1:0] md);
    int n;
    n = 0;
    model_push(int'(d), int'(md));
    @(negedge clk);
    x_valid = 1'b1;
    x_data  = d;
    mode    = md;
    while (!x_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: x_ready low for %0d cycles, required a transfer", n);
    end
    @(posedge clk);
    #1 x_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d outputs outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every output transfer is compared against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && prediction_valid && prediction_ready) begin
        mon_g.pred = prediction_data;
        mon_g.res  = residual_data;
        mon_g.last = prediction_last;
        got_q.push_back(mon_g);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got pred 0x%0h res 0x%0h, required no output",
                   mon_g.pred, mon_g.res);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_pred", mon_g.pred, mon_e.pred);
          chk("sb_res",  mon_g.res,  mon_e.res);
          chk("sb_last", mon_g.last, mon_e.last);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    x_valid = 1'b0;
    x_data = '0;
    mode = 2'd0;
    prediction_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", prediction_valid, 0);
    chk("rst_x_ready", x_ready, 1);
    chk("rst_pred", prediction_data, 0);
    chk("rst_res", residual_data, 0);
    chk("rst_last", prediction_last, 0);
    @(negedge clk);
    rst = 1'b1;

    // Ramp, average mode.
    got_q.delete();
    for (int i = 0; i < 16; i++) send(DW'(i), 2'd2);
    wait_drain();
    chk("t1_count", got_q.size(), 16);
    if (got_q.size() == 16) begin
      chk("t1_s0_pred", got_q[0].pred, 0);  chk("t1_s0_res", got_q[0].res, 0);
      chk("t1_s1_pred", got_q[1].pred, 0);  chk("t1_s1_res", got_q[1].res, 1);
      chk("t1_s4_pred", got_q[4].pred, 0);  chk("t1_s4_res", got_q[4].res, 4);
      chk("t1_s5_pred", got_q[5].pred, 2);  chk("t1_s5_res", got_q[5].res, 3);
      for (int i = 0; i < 16; i++) chk("t1_last", got_q[i].last, (i == 15) ? 1 : 0);
    end

    // Ramp, MED mode; mode input wanders mid-block and must be ignored.
    got_q.delete();
    for (int i = 0; i < 16; i++) send(DW'(i), (i == 0) ? 2'd3 : 2'(i));
    wait_drain();
    chk("t2_count", got_q.size(), 16);
    if (got_q.size() == 16) begin
      chk("t2_s5_pred", got_q[5].pred, 4);    chk("t2_s5_res", got_q[5].res, 1);
      chk("t2_s10_pred", got_q[10].pred, 9);  chk("t2_s10_res", got_q[10].res, 1);
    end

    // Constant block, MED mode.
    got_q.delete();
    for (int i = 0; i < 16; i++) send(16'h7FFF, 2'd3);
    wait_drain();
    chk("t3_count", got_q.size(), 16);
    if (got_q.size() == 16) begin
      chk("t3_s0_res", got_q[0].res, 17'h07FFF);
      for (int i = 1; i < 16; i++) chk("t3_res_zero", got_q[i].res, 0);
    end

    // Full-scale negative residual, left mode.
    got_q.delete();
    send(16'hFFFF, 2'd0);
    for (int i = 1; i < 16; i++) send(16'h0000, 2'd0);
    wait_drain();
    chk("t4_count", got_q.size(), 16);
    if (got_q.size() == 16) begin
      chk("t4_s1_pred", got_q[1].pred, 16'hFFFF);
      chk("t4_s1_res", got_q[1].res, 17'h10001);
      chk("t4_s2_pred", got_q[2].pred, 0);
    end

    // Back-pressure: drain held off for 10 cycles while the generator runs.
    got_q.delete();
    fork
      begin
        for (int i = 0; i < 16; i++) send(DW'(i), 2'd2);
      end
      begin
        repeat (4) @(posedge clk);
        #1 prediction_ready = 1'b0;
        repeat (10) begin
          @(negedge clk);
          chk("stall_x_ready", x_ready, 0);
          chk("stall_valid", prediction_valid, 1);
          if (exp_q.size() > 0) begin
            chk("stall_hold_pred", prediction_data, exp_q[0].pred);
            chk("stall_hold_res", residual_data, exp_q[0].res);
          end
        end
        @(posedge clk);
        #1 prediction_ready = 1'b1;
      end
    join
    wait_drain();
    chk("t5_count", got_q.size(), 16);
    if (got_q.size() == 16) begin
      chk("t5_s5_pred", got_q[5].pred, 2);  chk("t5_s5_res", got_q[5].res, 3);
      chk("t5_s15_last", got_q[15].last, 1);
    end

    // Reset in the middle of a block.
    got_q.delete();
    for (int i = 0; i < 7; i++) send(DW'(i), 2'd1);
    wait_drain();
    chk("t6_partial_count", got_q.size(), 7);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_valid", prediction_valid, 0);
    chk("t6_rst_pred", prediction_data, 0);
    chk("t6_rst_res", residual_data, 0);
    chk("t6_rst_last", prediction_last, 0);
    chk("t6_rst_x_ready", x_ready, 1);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    got_q.delete();
    for (int i = 0; i < 16; i++) send(DW'(i + 3), 2'd0);
    wait_drain();
    chk("t6_count", got_q.size(), 16);
    if (got_q.size() == 16) begin
      chk("t6_s0_pred", got_q[0].pred, 0);  chk("t6_s0_res", got_q[0].res, 3);
      chk("t6_s5_pred", got_q[5].pred, 7);  chk("t6_s5_res", got_q[5].res, 1);
      chk("t6_s15_last", got_q[15].last, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
